// File: rtl/instr_sequencer.sv
// instr_sequencer: RV32I multi-cycle fetch/decode/exec/writeback control FSM owning PC and RF write enable.
// Optional SEQ_ILLEGAL_TRAP_EN: unknown opcodes in DECODE trap to FAULT instead of executing as NOP.
module instr_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        dec_en,
  output logic        exe_en,
  input  logic        allow_wr,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        halted,
  output logic        fault
);
  localparam int CW = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_B = 7'b1100011, OP_SYS = 7'b1110011;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_FAULT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic br_q;
  logic [31:0] tgt_q;
  logic [6:0] op;
  logic writes;
  assign op = instr[6:0];
  assign writes = (op == OP_R || op == OP_I) && instr[11:7] != 5'd0;
  assign imem_addr = pc;
`ifdef SEQ_ILLEGAL_TRAP_EN
  logic legal;
  assign legal = op == OP_R || op == OP_I || op == OP_B || op == OP_SYS;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc <= RESET_PC;
      instr <= 32'd0;
      cnt <= '0;
      br_q <= 1'b0;
      tgt_q <= 32'd0;
      imem_req <= 1'b0;
      dec_en <= 1'b0;
      exe_en <= 1'b0;
      rf_we <= 1'b0;
      halted <= 1'b0;
      fault <= 1'b0;
    end else begin
      dec_en <= 1'b0;
      exe_en <= 1'b0;
      rf_we <= 1'b0;
      case (state)
        S_IDLE: begin
          state <= S_FETCH;
          imem_req <= 1'b1;
          cnt <= '0;
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr <= imem_rdata;
            state <= S_DECODE;
            imem_req <= 1'b0;
            dec_en <= 1'b1;
          end else if (cnt == CW'(FETCH_TIMEOUT - 1)) begin
            state <= S_FAULT;
            imem_req <= 1'b0;
            fault <= 1'b1;
          end else cnt <= cnt + CW'(1);
        end
        S_DECODE: begin
          if (op == OP_SYS) begin
            state <= S_HALT;
            halted <= 1'b1;
          end
`ifdef SEQ_ILLEGAL_TRAP_EN
          else if (!legal) begin
            state <= S_FAULT;
            fault <= 1'b1;
          end
`endif
          else begin
            state <= S_EXEC;
            exe_en <= 1'b1;
          end
        end
        S_EXEC: begin
          br_q <= br_taken;
          tgt_q <= br_target;
          rf_we <= allow_wr && writes;
          state <= S_WB;
        end
        S_WB: begin
          pc <= (op == OP_B && br_q) ? {tgt_q[31:2], 2'b00} : pc + 32'd4;
          state <= S_FETCH;
          imem_req <= 1'b1;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: table-driven directed checks of instr_sequencer plus timeout, halt, reset and trap sequences.
module tb_instr_sequencer;
  logic clk = 1'b0, rst = 1'b1, imem_req, imem_ack = 1'b0, dec_en, exe_en, allow_wr = 1'b0;
  logic br_taken = 1'b0, rf_we, halted, fault;
  logic [31:0] imem_addr, imem_rdata = 32'd0, instr, br_target = 32'd0, pc;
  int errors = 0, checks = 0;
  logic [2:0] prev_s = 3'b000;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .dec_en(dec_en), .exe_en(exe_en), .allow_wr(allow_wr),
    .br_taken(br_taken), .br_target(br_target), .rf_we(rf_we), .pc(pc), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op;
    int          waitc;
    logic        allow;
    logic        br;
    logic [31:0] tgt;
    logic        exp_we;
    logic [31:0] exp_pc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  // Strobes must be one-hot-or-zero and never repeat on back-to-back cycles.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (32'(dec_en) + 32'(exe_en) + 32'(rf_we) > 1 || (prev_s & {dec_en, exe_en, rf_we}) != 3'b000) begin
        errors++;
        $display("FAIL strobe_excl: got %b prev %b", {dec_en, exe_en, rf_we}, prev_s);
      end
    end
    prev_s = rst ? 3'b000 : {dec_en, exe_en, rf_we};
  end

  task automatic run(input vec_t v, input logic [31:0] addr);
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, addr);
    repeat (v.waitc) begin
      step;
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, addr);
    end
    imem_ack = 1'b1;
    imem_rdata = v.op;
    step;
    imem_ack = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("dec_en", dec_en, 1);
    chk("req_drop", imem_req, 0);
    chk("instr", instr, v.op);
    allow_wr = v.allow;
    br_taken = v.br;
    br_target = v.tgt;
    step;
    chk("exe_en", exe_en, 1);
    step;
    br_taken = ~v.br;
    br_target = 32'h0BAD_0000;
    imem_ack = 1'b1;
    chk("rf_we", rf_we, 32'(v.exp_we));
    step;
    imem_ack = 1'b0;
    chk("instr_keep", instr, v.op);
    chk("next_pc", pc, v.exp_pc);
  endtask

  task automatic reset_seq;
    rst = 1'b1;
    step;
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_flags", {halted, fault, dec_en, exe_en, rf_we}, 0);
    rst = 1'b0;
    step;
  endtask

  vec_t vt[9];
  logic [31:0] addr, hold_pc;

  initial begin
    vt[0] = '{32'h0050_0093, 0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0004};
    vt[1] = '{32'h0000_0033, 3, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0008};
    vt[2] = '{32'h0020_81B3, 1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_000C};
    vt[3] = '{32'h0020_81B3, 0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0010};
    vt[4] = '{32'h0000_0063, 0, 1'b1, 1'b1, 32'h0000_0103, 1'b0, 32'h0000_0100};
    vt[5] = '{32'h0000_0063, 2, 1'b1, 1'b0, 32'h0000_0103, 1'b0, 32'h0000_0104};
    vt[6] = '{32'h0050_0093, 0, 1'b1, 1'b1, 32'h0000_0500, 1'b1, 32'h0000_0108};
    vt[7] = '{32'h0000_0063, 0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFC};
    vt[8] = '{32'h0050_0093, 0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000};
    repeat (2) step;
    reset_seq;
    addr = 32'h0;
    for (int i = 0; i < 9; i++) begin
      run(vt[i], addr);
      addr = vt[i].exp_pc;
    end
`ifndef SEQ_ILLEGAL_TRAP_EN
    run('{32'h0000_007F, 0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0000_0004}, addr);
    addr = 32'h4;
`endif
    chk("ecall_req", imem_req, 1);
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_0073;
    step;
    imem_ack = 1'b0;
    chk("ecall_dec", dec_en, 1);
    step;
    chk("halted", halted, 1);
    chk("halt_exe", exe_en, 0);
    hold_pc = pc;
    chk("halt_pc", hold_pc, addr);
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    for (int i = 0; i < 20; i++) begin
      step;
      chk("halt_req", imem_req, 0);
      chk("halt_pc_frozen", pc, hold_pc);
      chk("halt_instr", instr, 32'h0000_0073);
    end
    imem_ack = 1'b0;

    reset_seq;
    for (int i = 0; i < 16; i++) begin
      chk("to_req", imem_req, 1);
      chk("to_nofault", fault, 0);
      step;
    end
    chk("to_fault", fault, 1);
    chk("to_req_low", imem_req, 0);
    repeat (3) step;
    chk("fault_sticky", fault, 1);
    chk("fault_dec", dec_en, 0);

    reset_seq;
    for (int i = 0; i < 15; i++) begin
      chk("late_req", imem_req, 1);
      step;
    end
    imem_ack = 1'b1;
    imem_rdata = 32'h0050_0093;
    step;
    imem_ack = 1'b0;
    chk("late_dec", dec_en, 1);
    chk("late_nofault", fault, 0);
    repeat (3) step;
    chk("late_pc", pc, 32'h4);
    step;
    chk("mid_req", imem_req, 1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_pc", pc, 32'h0);
    step;
`ifdef SEQ_ILLEGAL_TRAP_EN
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_007F;
    step;
    imem_ack = 1'b0;
    chk("trap_dec", dec_en, 1);
    step;
    chk("trap_fault", fault, 1);
    chk("trap_exe", exe_en, 0);
    chk("trap_pc", pc, 32'h0);
    step;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
